// File: rtl/addsub_accumulator.sv
// Purpose: accumulator that LOADs, ADDs, SUBs or CLEARs one operand per handshake and flags the result.
// Latency: operation accepted at edge E0, result and out_valid visible after edge E1; one op per 3 cycles at best.
// Backpressure: result held stable in DONE while out_ready=0; in_ready stays low until the result is taken.
module addsub_accumulator #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] acc,
  output logic             carry,
  output logic             overflow,
  output logic             sticky_ovf,
  output logic             zero,
  output logic [7:0]       op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  state_t           state;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] operand_q;

  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             sum_ovf;

  logic [WIDTH-1:0] acc_nxt;
  logic             carry_nxt;
  logic             ovf_nxt;
  logic             sticky_nxt;

  // Handshake outputs decode straight from the state register; reset masks in_ready.
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);

  // Adder/subtractor: subtract is invert-and-carry-in on the latched operand.
  always_comb begin
    is_sub  = (op_q == OP_SUB);
    b_eff   = operand_q ^ {WIDTH{is_sub}};
    sum     = {1'b0, acc} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    sum_ovf = (acc[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != acc[WIDTH-1]);
  end

  // Next accumulator value and flags for the latched operation.
  always_comb begin
    acc_nxt    = '0;
    carry_nxt  = 1'b0;
    ovf_nxt    = 1'b0;
    sticky_nxt = 1'b0;
    case (op_q)
      OP_LOAD: begin
        acc_nxt = operand_q;
      end
      OP_ADD, OP_SUB: begin
        acc_nxt    = sum[WIDTH-1:0];
        carry_nxt  = sum[WIDTH];
        ovf_nxt    = sum_ovf;
        sticky_nxt = sticky_ovf | sum_ovf;
      end
      OP_CLEAR: begin
        acc_nxt = '0;
      end
      default: begin
        acc_nxt = '0;
      end
    endcase
  end

  // Control FSM plus result registers; results only move on the EXEC -> DONE edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= OP_LOAD;
      operand_q  <= '0;
      acc        <= '0;
      carry      <= 1'b0;
      overflow   <= 1'b0;
      sticky_ovf <= 1'b0;
      zero       <= 1'b1;
      op_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q      <= op;
            operand_q <= operand;
            state     <= EXEC;
          end
        end
        EXEC: begin
          acc        <= acc_nxt;
          carry      <= carry_nxt;
          overflow   <= ovf_nxt;
          sticky_ovf <= sticky_nxt;
          zero       <= (acc_nxt == '0);
          op_count   <= op_count + 8'd1;
          state      <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_accumulator.sv
// Directed bench for addsub_accumulator (WIDTH=4): reset, arithmetic/flags, backpressure, reset mid-op.
// Inputs are driven on the falling edge; outputs are sampled on the falling edge or 1-2 time units after a rising edge.
// All expected values are hand-computed constants.
module tb_addsub_accumulator;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic             overflow;
  logic             sticky_ovf;
  logic             zero;
  logic [7:0]       op_count;

  int n_checks;
  int n_fail;

  localparam logic [1:0] LOAD  = 2'b00;
  localparam logic [1:0] ADD   = 2'b01;
  localparam logic [1:0] SUB   = 2'b10;
  localparam logic [1:0] CLEAR = 2'b11;

  addsub_accumulator #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .operand    (operand),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .acc        (acc),
    .carry      (carry),
    .overflow   (overflow),
    .sticky_ovf (sticky_ovf),
    .zero       (zero),
    .op_count   (op_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one op from the falling edge; leaves the bench at a falling edge with the result in DONE.
  task automatic issue(input string tag, input logic [1:0] o, input logic [WIDTH-1:0] d);
    check({tag, " in_ready before issue"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    op       = o;
    operand  = d;
    @(posedge clk);
    #1;
    // Scramble the request after acceptance; the latched copy must be used.
    in_valid = 1'b0;
    op       = ~o;
    operand  = ~d;
    @(negedge clk);
    check({tag, " out_valid in EXEC"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready in EXEC"}, 32'(in_ready), 32'd0);
    @(negedge clk);
    check({tag, " out_valid after 2 edges"}, 32'(out_valid), 32'd1);
  endtask

  // Take the result: out_valid drops and in_ready rises on the same edge.
  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, " out_valid after take"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready after take"}, 32'(in_ready), 32'd1);
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic expect_res(input string tag, input logic [WIDTH-1:0] e_acc, input logic e_c,
                            input logic e_v, input logic e_s, input logic e_z, input logic [7:0] e_cnt);
    check({tag, " acc"}, 32'(acc), 32'(e_acc));
    check({tag, " carry"}, 32'(carry), 32'(e_c));
    check({tag, " overflow"}, 32'(overflow), 32'(e_v));
    check({tag, " sticky_ovf"}, 32'(sticky_ovf), 32'(e_s));
    check({tag, " zero"}, 32'(zero), 32'(e_z));
    check({tag, " op_count"}, 32'(op_count), 32'(e_cnt));
  endtask

  task automatic run(input string tag, input logic [1:0] o, input logic [WIDTH-1:0] d,
                     input logic [WIDTH-1:0] e_acc, input logic e_c, input logic e_v,
                     input logic e_s, input logic e_z, input logic [7:0] e_cnt);
    issue(tag, o, d);
    expect_res(tag, e_acc, e_c, e_v, e_s, e_z, e_cnt);
    consume(tag);
  endtask

  initial begin
    logic [WIDTH-1:0] held_acc;
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    op        = LOAD;
    operand   = '0;
    out_ready = 1'b0;

    // Power-on reset.
    repeat (2) @(negedge clk);
    check("por in_ready during rst", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    expect_res("por", 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    check("por out_valid", 32'(out_valid), 32'd0);
    check("por in_ready after release", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Load something, then reset asynchronously mid-cycle with no clock edge.
    run("pre", LOAD, 4'd5, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    expect_res("async rst", 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    check("async rst out_valid", 32'(out_valid), 32'd0);
    check("async rst in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("async rst in_ready after release", 32'(in_ready), 32'd1);
    @(negedge clk);

    // ADD with signed overflow.
    run("load5", LOAD, 4'd5, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    run("add6",  ADD,  4'd6, 4'd11, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2);

    // SUB cases.
    run("load9",  LOAD, 4'd9,  4'd9,  1'b0, 1'b0, 1'b0, 1'b0, 8'd3);
    run("sub8",   SUB,  4'd8,  4'd1,  1'b1, 1'b0, 1'b0, 1'b0, 8'd4);
    run("load12", LOAD, 4'd12, 4'd12, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5);
    run("sub3",   SUB,  4'd3,  4'd9,  1'b1, 1'b0, 1'b0, 1'b0, 8'd6);
    run("load3",  LOAD, 4'd3,  4'd3,  1'b0, 1'b0, 1'b0, 1'b0, 8'd7);
    run("sub5",   SUB,  4'd5,  4'd14, 1'b0, 1'b0, 1'b0, 1'b0, 8'd8);

    // Wrap and sticky overflow.
    run("load15", LOAD,  4'd15, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 8'd9);
    run("add1w",  ADD,   4'd1,  4'd0,  1'b1, 1'b0, 1'b0, 1'b1, 8'd10);
    run("load7",  LOAD,  4'd7,  4'd7,  1'b0, 1'b0, 1'b0, 1'b0, 8'd11);
    run("add1v",  ADD,   4'd1,  4'd8,  1'b0, 1'b1, 1'b1, 1'b0, 8'd12);
    run("add0",   ADD,   4'd0,  4'd8,  1'b0, 1'b0, 1'b1, 1'b0, 8'd13);
    run("clear",  CLEAR, 4'd9,  4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 8'd14);

    // Backpressure: hold the result in DONE for 5 cycles while pulsing ADD 1.
    run("load2", LOAD, 4'd2, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd15);
    issue("add4", ADD, 4'd4);
    expect_res("add4", 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 8'd16);
    held_acc = acc;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      op       = ADD;
      operand  = 4'd1;
      @(negedge clk);
      check("bp acc stable", 32'(acc), 32'd6);
      check("bp out_valid", 32'(out_valid), 32'd1);
      check("bp in_ready", 32'(in_ready), 32'd0);
      check("bp op_count", 32'(op_count), 32'd16);
    end
    in_valid = 1'b0;
    consume("bp");
    check("bp acc after take", 32'(acc), 32'(held_acc));
    check("bp op_count after take", 32'(op_count), 32'd16);

    // Reset while an ADD 3 onto acc=4 is in EXEC: the op is dropped.
    run("load4", LOAD, 4'd4, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 8'd17);
    in_valid = 1'b1;
    op       = ADD;
    operand  = 4'd3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check("midop acc", 32'(acc), 32'd0);
    check("midop op_count", 32'(op_count), 32'd0);
    check("midop out_valid", 32'(out_valid), 32'd0);
    check("midop zero", 32'(zero), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("midop no result", 32'(out_valid), 32'd0);
      check("midop acc held", 32'(acc), 32'd0);
    end
    check("midop in_ready", 32'(in_ready), 32'd1);

    // Accumulator usable again after the dropped op.
    run("post add5", ADD, 4'd5, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net against a stalled bench.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/addsub_accumulator.md
# addsub_accumulator

Sequential accumulator stage that sits directly downstream of the 4-bit ripple adder/subtractor datapath. It accepts one operation per handshake, adds or subtracts the operand into an internal accumulator using the two's-complement invert-and-carry-in scheme, and registers the result with carry, signed-overflow, sticky-overflow and zero flags. It presents each result on a valid/ready output port until a consumer takes it.

## Interface
- WIDTH, 4, datapath width of accumulator and operand (minimum 2)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operation request present
- in_ready  output  1  block can accept an operation this cycle
- op  input  2  00 LOAD (acc=operand), 01 ADD (acc=acc+operand), 10 SUB (acc=acc-operand), 11 CLEAR (acc=0)
- operand  input  WIDTH  operand for LOAD/ADD/SUB, ignored for CLEAR
- out_valid  output  1  result registers hold an unconsumed result
- out_ready  input  1  consumer takes the result this cycle
- acc  output  WIDTH  accumulator value
- carry  output  1  carry-out of the MSB for the last ADD/SUB; for SUB, 1 = no borrow
- overflow  output  1  signed overflow of the last operation
- sticky_ovf  output  1  OR of overflow since the last LOAD/CLEAR
- zero  output  1  acc == 0
- op_count  output  8  completed operations, wraps 255 -> 0

## Operation
- FSM states: IDLE, EXEC, DONE. Reset state is IDLE.
- IDLE:
  - in_ready=1.
  - On a clock edge with in_valid=1: latch op and operand, then go to EXEC.
  - Changes to op or operand after acceptance have no effect.
- EXEC:
  - in_ready=0.
  - Compute sum = acc + (operand XOR {WIDTH{sub}}) + sub, with sub=1 only for SUB.
  - At the edge: update acc, carry, overflow, sticky_ovf, zero and op_count, then go to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - On an edge with out_ready=1, go to IDLE.
  - With out_ready=0, hold all outputs stable indefinitely.
- Flag rules:
  - ADD/SUB: carry = bit WIDTH of the (WIDTH+1)-bit sum. overflow = 1 when the MSBs of acc and the effective operand (post-XOR) are equal and the sum MSB differs from them.
  - LOAD/CLEAR: carry=0, overflow=0, sticky_ovf=0.
  - ADD/SUB: sticky_ovf |= overflow.
  - zero is computed from the new acc.
- Arithmetic is modulo 2^WIDTH; no saturation.

## Timing
- Reset:
  - rst asserted at any time forces state=IDLE immediately, regardless of clock.
  - Reset values: acc=0, carry=0, overflow=0, sticky_ovf=0, zero=1, op_count=0, out_valid=0.
  - in_ready=0 while rst=1, and 1 on the first cycle after deassertion.
  - An operation in flight (EXEC or DONE) when reset asserts is discarded.
- Latency: request accepted at edge E0, result and out_valid=1 visible after E1 (2 cycles from in_valid sampled to result).
- Throughput: at most one operation per 3 cycles with out_ready held high.
- in_valid is ignored outside IDLE; the upstream must hold the request until in_ready=1.
- out_valid falls at the edge after out_ready=1 is sampled in DONE. in_ready rises on that same edge.
- acc, flags and op_count change only at the EXEC -> DONE edge or on reset.

## Test plan
- Reset:
  - Assert rst mid-cycle with no clock.
  - Outputs go immediately to acc=0, zero=1, all other flags 0, op_count=0, out_valid=0, in_ready=0.
  - After release, in_ready=1.
- ADD overflow (WIDTH=4):
  - LOAD 5 -> acc=5, zero=0.
  - Then ADD 6 -> acc=11, carry=0, overflow=1, sticky_ovf=1.
  - op_count=2; out_valid asserted 2 cycles after each accept.
- SUB:
  - LOAD 9, SUB 8 -> acc=1, carry=1, overflow=0.
  - LOAD 12, SUB 3 -> acc=9, carry=1, overflow=0.
  - LOAD 3, SUB 5 -> acc=14, carry=0 (borrow), overflow=0.
- Wrap and sticky:
  - LOAD 15, ADD 1 -> acc=0, carry=1, zero=1, overflow=0.
  - LOAD 7, ADD 1 -> acc=8, overflow=1, sticky_ovf=1.
  - ADD 0 -> overflow=0, sticky_ovf=1.
  - CLEAR -> acc=0, sticky_ovf=0, zero=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with op=ADD, operand=1.
  - Required: acc stable, out_valid=1, in_ready=0, pulses ignored.
  - Raise out_ready -> out_valid=0 and in_ready=1 on the next edge.
- Reset mid-operation:
  - Assert rst while in EXEC after accepting ADD 3 onto acc=4.
  - Required: acc=0, op_count=0, out_valid=0 immediately; no result is ever presented for the dropped ADD.
